data_memory_ctrl: RTL and testbench

Parametrised, byte-addressed, big-endian data memory for the CPU data path, with a request/ready handshake and configurable wait states. It supports byte, half-word and full-word accesses. Loads can be sign- or zero-extended. Out-of-range and illegal requests raise an error flag. It replaces the fixed 32-bit, zero-latency data memory wherever a multi-cycle or sub-word-capable memory stage is needed.

---
 rtl/data_memory_ctrl.sv | 172 +++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// Byte-addressed big-endian data memory with request/ready handshake and WAIT_CYCLES wait states.
// Define MEM_ALIGN_CHECK_EN to reject accesses whose address is not a multiple of the access size.
module data_memory_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 2048,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic [1:0]            size,
  input  logic                  signedLoad,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  ready,
  output logic                  busy,
  output logic                  error
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    rd_q, rd_d, wr_q, wr_d, sgn_q, sgn_d, err_q, err_d;
  logic [1:0]              size_q, size_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;

  logic [7:0]              mem [DEPTH];

  // With no wait states the access happens on the sampling edge, so it must use the live inputs.
  logic                    acc_rd, acc_wr, acc_sgn;
  logic [1:0]              acc_size;
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic [DATA_WIDTH-1:0]   acc_wdata;
  logic                    live;

  assign live      = (state_q == ST_IDLE);
  assign acc_rd    = live ? memRead    : rd_q;
  assign acc_wr    = live ? memWrite   : wr_q;
  assign acc_sgn   = live ? signedLoad : sgn_q;
  assign acc_size  = live ? size       : size_q;
  assign acc_addr  = live ? address    : addr_q;
  assign acc_wdata = live ? WriteData  : wdata_q;

  int                      acc_n;
  logic [ADDR_WIDTH:0]     last_byte;
  logic [MAW-1:0]          base;
  logic                    misaligned, reject, access, mem_we, fill;
  logic [DATA_WIDTH-1:0]   load_val;

  assign acc_n     = 1 << acc_size;
  assign base      = acc_addr[MAW-1:0];
  assign last_byte = {1'b0, acc_addr} + (ADDR_WIDTH+1)'(acc_n - 1);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (acc_addr & ADDR_WIDTH'(acc_n - 1)) != '0;
`else
  assign misaligned = 1'b0;
`endif

  assign reject = (acc_rd && acc_wr) || (acc_n > NB) ||
                  (last_byte >= (ADDR_WIDTH+1)'(DEPTH)) || misaligned;

  // Mem[a] is the most-significant byte; bytes above the access take the sign or zero fill.
  always_comb begin
    load_val = '0;
    fill     = acc_sgn & mem[base][7];
    for (int j = 0; j < NB; j++) begin
      if (j < acc_n) load_val[8*j +: 8] = mem[base + MAW'(acc_n - 1 - j)];
      else           load_val[8*j +: 8] = {8{fill}};
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    sgn_d   = sgn_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    access  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (memRead || memWrite) begin
          rd_d    = memRead;
          wr_d    = memWrite;
          sgn_d   = signedLoad;
          size_d  = size;
          addr_d  = address;
          wdata_d = WriteData;
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end else begin
            access  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          access  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (access) begin
      err_d = reject;
      if (acc_rd) rdata_d = reject ? '0 : load_val;
    end
  end

  // Gating with rst_n keeps an access edge that coincides with reset from touching the array.
  assign mem_we = access && acc_wr && !reject && rst_n;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      sgn_q   <= sgn_d;
      err_q   <= err_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // NOTE: the byte array is deliberately not reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (i < acc_n) mem[base + MAW'(i)] <= acc_wdata[8*(acc_n - 1 - i) +: 8];
      end
    end
  end

  assign ReadData = rdata_q;
  assign ready    = (state_q == ST_DONE);
  assign busy     = (state_q != ST_IDLE);
  assign error    = (state_q == ST_DONE) && err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl: one instance with no wait states, one with three,
// a byte-array reference model and a scoreboard of expected completions.
module tb_data_memory_ctrl;

  localparam int DEPTH = 2048;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read [2];
  logic        mem_write [2];
  logic        signed_load [2];
  logic [1:0]  size_in [2];
  logic [31:0] address [2];
  logic [31:0] write_data [2];
  logic [31:0] read_data [2];
  logic        ready [2];
  logic        busy [2];
  logic        error [2];

  always #5 clk = ~clk;

  data_memory_ctrl #(.DATA_WIDTH(32), .DEPTH(DEPTH), .ADDR_WIDTH(32), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .memRead(mem_read[0]), .memWrite(mem_write[0]),
    .size(size_in[0]), .signedLoad(signed_load[0]), .address(address[0]),
    .WriteData(write_data[0]), .ReadData(read_data[0]), .ready(ready[0]),
    .busy(busy[0]), .error(error[0])
  );

  data_memory_ctrl #(.DATA_WIDTH(32), .DEPTH(DEPTH), .ADDR_WIDTH(32), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .memRead(mem_read[1]), .memWrite(mem_write[1]),
    .size(size_in[1]), .signedLoad(signed_load[1]), .address(address[1]),
    .WriteData(write_data[1]), .ReadData(read_data[1]), .ready(ready[1]),
    .busy(busy[1]), .error(error[1])
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  model [2][DEPTH];
  logic [31:0] last_rd [2];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      check({tag, "_ready"}, 32'(ready[k]), 32'd0);
      check({tag, "_busy"},  32'(busy[k]),  32'd0);
      check({tag, "_error"}, 32'(error[k]), 32'd0);
      check({tag, "_rdata"}, read_data[k],  32'd0);
    end
  endtask

  // Drive one request, predict its outcome, then wait for the completion pulse and compare.
  // With poke set, a write of 0xAAAAAAAA to address 0 is held during busy and must be ignored.
  task automatic txn(input string tag, input int k, input bit rd, input bit wr,
                     input logic [1:0] sz, input bit sg, input logic [31:0] addr,
                     input logic [31:0] wd, input bit poke);
    exp_t        e;
    int          n, got, busy_cnt, lat;
    bit          rej;
    logic [63:0] last;
    logic [31:0] v;
    n    = 1 << sz;
    lat  = (k == 0) ? 1 : 4;
    last = {32'd0, addr} + 64'(n - 1);
    rej  = (rd && wr) || (n > 4) || (last >= 64'(DEPTH));
`ifdef MEM_ALIGN_CHECK_EN
    if ((int'(addr[2:0]) & (n - 1)) != 0) rej = 1'b1;
`endif
    if (!rej && wr)
      for (int i = 0; i < n; i++) model[k][addr + i] = wd[8*(n-1-i) +: 8];
    if (rd) begin
      v = '0;
      if (!rej) begin
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(model[k][addr + i]);
        if (sg && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
      end
      last_rd[k] = v;
    end
    e.rdata = last_rd[k];
    e.err   = rej;
    sb.push_back(e);

    @(negedge clk);
    mem_read[k]    = rd;
    mem_write[k]   = wr;
    size_in[k]     = sz;
    signed_load[k] = sg;
    address[k]     = addr;
    write_data[k]  = wd;
    @(posedge clk);
    #1;
    mem_read[k]  = 1'b0;
    mem_write[k] = 1'b0;

    got = 0;
    busy_cnt = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (busy[k]) busy_cnt++;
      if (ready[k]) begin
        got = cyc;
        break;
      end
      if (poke) begin
        mem_write[k]  = 1'b1;
        size_in[k]    = 2'd2;
        address[k]    = 32'd0;
        write_data[k] = 32'hAAAA_AAAA;
      end
    end
    mem_write[k] = 1'b0;

    check({tag, "_latency"}, 32'(got), 32'(lat));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(lat));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_rdata"}, read_data[k], e.rdata);
      check({tag, "_error"}, 32'(error[k]), 32'(e.err));
    end
    @(negedge clk);
    check({tag, "_ready_pulse"}, 32'(ready[k]), 32'd0);
    check({tag, "_busy_end"}, 32'(busy[k]), 32'd0);
  endtask

  task automatic expect_no_ready(input string tag, input int k, input int cycles);
    int seen;
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (ready[k]) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      mem_read[k] = 1'b0; mem_write[k] = 1'b0; signed_load[k] = 1'b0;
      size_in[k] = 2'd0; address[k] = '0; write_data[k] = '0; last_rd[k] = '0;
    end
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Zero-wait instance: word, sub-word and sign/zero-extended accesses.
    txn("w_word0",      0, 0, 1, 2'd2, 0, 32'd0,    32'h1122_3344, 0);
    txn("r_word0",      0, 1, 0, 2'd2, 0, 32'd0,    32'd0,         0);
    txn("r_byte1_s",    0, 1, 0, 2'd0, 1, 32'd1,    32'd0,         0);
    txn("w_byte3",      0, 0, 1, 2'd0, 0, 32'd3,    32'h0000_00F0, 0);
    txn("r_half2_s",    0, 1, 0, 2'd1, 1, 32'd2,    32'd0,         0);
    txn("r_byte3_s",    0, 1, 0, 2'd0, 1, 32'd3,    32'd0,         0);
    txn("r_byte3_u",    0, 1, 0, 2'd0, 0, 32'd3,    32'd0,         0);
    txn("r_half0_s",    0, 1, 0, 2'd1, 1, 32'd0,    32'd0,         0);
    // Range and legality rejections, including a rejected write leaving the array intact.
    txn("w_half2046",   0, 0, 1, 2'd1, 0, 32'd2046, 32'h0000_CAFE, 0);
    txn("r_word2046",   0, 1, 0, 2'd2, 0, 32'd2046, 32'd0,         0);
    txn("r_half2046a",  0, 1, 0, 2'd1, 0, 32'd2046, 32'd0,         0);
    txn("w_word2046",   0, 0, 1, 2'd2, 0, 32'd2046, 32'h1234_5678, 0);
    txn("r_half2046b",  0, 1, 0, 2'd1, 1, 32'd2046, 32'd0,         0);
    txn("rw_both",      0, 1, 1, 2'd2, 0, 32'd0,    32'h9999_9999, 0);
    txn("r_word0_post", 0, 1, 0, 2'd2, 0, 32'd0,    32'd0,         0);
    txn("r_size3",      0, 1, 0, 2'd3, 0, 32'd0,    32'd0,         0);
    txn("r_addr_huge",  0, 1, 0, 2'd0, 0, 32'hFFFF_FFFF, 32'd0,    0);
    txn("r_byte2047",   0, 1, 0, 2'd0, 0, 32'd2047, 32'd0,         0);
    // Unaligned word: legal by default, rejected with the alignment check enabled.
    txn("w_word2",      0, 0, 1, 2'd2, 0, 32'd2,    32'hA1B2_C3D4, 0);
    txn("r_word2",      0, 1, 0, 2'd2, 0, 32'd2,    32'd0,         0);
    txn("r_word0_end",  0, 1, 0, 2'd2, 0, 32'd0,    32'd0,         0);

    // Three-wait instance: latency, busy window, requests ignored while busy.
    txn("w3_word0",     1, 0, 1, 2'd2, 0, 32'd0,    32'h5566_7788, 0);
    txn("r3_word0_poke",1, 1, 0, 2'd2, 0, 32'd0,    32'd0,         1);
    expect_no_ready("r3_no_extra_ready", 1, 6);
    txn("r3_word0_again",1, 1, 0, 2'd2, 0, 32'd0,   32'd0,         0);
    txn("w3_word8",     1, 0, 1, 2'd2, 0, 32'd8,    32'h0102_0304, 0);
    txn("r3_byte9_s",   1, 1, 0, 2'd0, 1, 32'd9,    32'd0,         0);

    // Reset during WAIT aborts the pending write with no completion pulse.
    @(negedge clk);
    mem_write[1] = 1'b1; size_in[1] = 2'd2; address[1] = 32'd8; write_data[1] = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    mem_write[1] = 1'b0;
    @(negedge clk);
    check("abort_busy_before_reset", 32'(busy[1]), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_in_wait");
    last_rd[0] = '0;
    last_rd[1] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    expect_no_ready("abort_no_ready", 1, 6);
    txn("r3_word8_after_reset", 1, 1, 0, 2'd2, 0, 32'd8, 32'd0, 0);
    txn("r_word2_after_reset",  0, 1, 0, 2'd2, 0, 32'd2, 32'd0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
